// File: rtl/match_event_reporter.sv
// Match event reporter: timestamps each qualified detector match with an index and gap,
// buffers reports in a small FIFO drained over valid/ready, and tracks count/overflow/burst.
module match_event_reporter #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned GAP_W    = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned WINDOW   = 16,
  parameter int unsigned BURST_TH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             y,
  input  logic             clear,
  input  logic             rpt_ready,
  output logic             rpt_valid,
  output logic [CNT_W-1:0] rpt_idx,
  output logic [GAP_W-1:0] rpt_gap,
  output logic [CNT_W-1:0] match_count,
  output logic             overflow,
  output logic             burst
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned RW = $clog2(BURST_TH + 1);
  localparam int unsigned EW = CNT_W + GAP_W;

  localparam logic [GAP_W-1:0] GapMax = '1;
  localparam logic [GAP_W-1:0] WinGap = GAP_W'(WINDOW);
  localparam logic [RW-1:0]    RunTh  = RW'(BURST_TH);
  localparam logic [CW-1:0]    Full   = CW'(DEPTH);

  logic [EW-1:0]    mem_q [DEPTH];
  logic [EW-1:0]    mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    fill_q, fill_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]    run_q, run_d;
  logic             first_q, first_d;
  logic             ovf_q, ovf_d;
  logic             burst_q, burst_d;

  logic             match, pop, full, push_ok;
  logic [GAP_W-1:0] gap_rep;

  always_comb begin
    match    = en & y;
    pop      = rpt_valid & rpt_ready;
    full     = (fill_q == Full);
    gap_rep  = (gap_cnt_q == GapMax) ? GapMax : gap_cnt_q + 1'b1;
    // A full FIFO can still take a push when the head leaves on the same edge.
    push_ok  = match & (~full | pop);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    gap_cnt_d = gap_cnt_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    first_d  = first_q;
    ovf_d    = ovf_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = {cnt_q, gap_rep};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_ok && !pop) begin
      fill_d = fill_q + 1'b1;
    end else if (!push_ok && pop) begin
      fill_d = fill_q - 1'b1;
    end
    if (match && !push_ok) begin
      ovf_d = 1'b1;
    end

    if (match) begin
      gap_cnt_d = '0;
      cnt_d     = cnt_q + 1'b1;
      first_d   = 1'b0;
      if (first_q || gap_rep > WinGap) begin
        run_d = RW'(1);
      end else if (run_q != RunTh) begin
        run_d = run_q + 1'b1;
      end
    end else if (en) begin
      if (gap_cnt_q != GapMax) begin
        gap_cnt_d = gap_cnt_q + 1'b1;
      end
      if (gap_cnt_q == WinGap) begin
        run_d = '0;
      end
    end

    if (clear) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      fill_d    = '0;
      gap_cnt_d = '0;
      cnt_d     = '0;
      run_d     = '0;
      first_d   = 1'b1;
      ovf_d     = 1'b0;
    end

    burst_d = (run_d >= RunTh);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      gap_cnt_q <= '0;
      cnt_q     <= '0;
      run_q     <= '0;
      first_q   <= 1'b1;
      ovf_q     <= 1'b0;
      burst_q   <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      gap_cnt_q <= gap_cnt_d;
      cnt_q     <= cnt_d;
      run_q     <= run_d;
      first_q   <= first_d;
      ovf_q     <= ovf_d;
      burst_q   <= burst_d;
    end
  end

  // Head fields read as zero while empty so a drained FIFO shows no stale report.
  always_comb begin
    rpt_valid          = (fill_q != '0);
    {rpt_idx, rpt_gap} = rpt_valid ? mem_q[rd_ptr_q] : '0;
    match_count        = cnt_q;
    overflow           = ovf_q;
    burst              = burst_q;
  end

endmodule

// File: tb/tb_match_event_reporter.sv
// Scoreboard bench for match_event_reporter: a behavioural model predicts reports and status,
// a negedge monitor checks delivered reports, a post-edge monitor checks status outputs.
module tb_match_event_reporter;

  localparam int DEPTH = 4;
  localparam int WINDOW = 16;
  localparam int BURST_TH = 3;
  localparam int GAP_MAX = 255;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0, y = 1'b0, clear = 1'b0, rpt_ready = 1'b0;
  logic       rpt_valid, overflow, burst;
  logic [7:0] rpt_idx, rpt_gap, match_count;

  match_event_reporter dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .y          (y),
    .clear      (clear),
    .rpt_ready  (rpt_ready),
    .rpt_valid  (rpt_valid),
    .rpt_idx    (rpt_idx),
    .rpt_gap    (rpt_gap),
    .match_count(match_count),
    .overflow   (overflow),
    .burst      (burst)
  );

  always #5 clk = ~clk;

  typedef struct {int idx; int gap;} rpt_t;
  rpt_t exp_q[$];
  rpt_t mon_e;

  int vectors = 0;
  int miscompares = 0;

  // Model state: what the block should hold after the coming edge.
  int m_n, m_gap, m_cnt, m_run, m_ovf, m_burst;
  bit m_first;

  task automatic chk(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic model_clear();
    m_n = 0; m_gap = 0; m_cnt = 0; m_run = 0; m_ovf = 0; m_burst = 0; m_first = 1;
    exp_q.delete();
  endtask

  // Apply one cycle of inputs, advance the model, then wait past the edge.
  task automatic step(input bit e, input bit yy, input bit r, input bit c);
    bit pop;
    int g;
    rpt_t t;
    en = e; y = yy; rpt_ready = r; clear = c;
    pop = (m_n > 0) && r;
    if (c) begin
      model_clear();
    end else begin
      if (e && yy) begin
        g = (m_gap + 1 > GAP_MAX) ? GAP_MAX : m_gap + 1;
        if (m_first || g > WINDOW) m_run = 1;
        else m_run = (m_run + 1 > BURST_TH) ? BURST_TH : m_run + 1;
        m_first = 0;
        if (m_n == DEPTH && !pop) begin
          m_ovf = 1;
        end else begin
          t.idx = m_cnt; t.gap = g;
          exp_q.push_back(t);
          m_n = m_n + 1;
        end
        m_cnt = (m_cnt + 1) % 256;
        m_gap = 0;
      end else if (e) begin
        if (m_gap == WINDOW) m_run = 0;
        m_gap++;
      end
      if (pop) m_n--;
      m_burst = (m_run >= BURST_TH) ? 1 : 0;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    #1;
    chk("reset_valid", int'(rpt_valid), 0);
    chk("reset_idx", int'(rpt_idx), 0);
    chk("reset_gap", int'(rpt_gap), 0);
    chk("reset_count", int'(match_count), 0);
    chk("reset_ovf", int'(overflow), 0);
    chk("reset_burst", int'(burst), 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Report monitor: a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (!reset && !clear && rpt_valid && rpt_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_report: got idx %0d gap %0d, expected none", rpt_idx, rpt_gap);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rpt_idx", int'(rpt_idx), mon_e.idx);
        chk("rpt_gap", int'(rpt_gap), mon_e.gap);
      end
    end
  end

  // Status monitor, sampled just after each edge.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      chk("rpt_valid", int'(rpt_valid), (m_n > 0) ? 1 : 0);
      chk("match_count", int'(match_count), m_cnt);
      chk("overflow", int'(overflow), m_ovf);
      chk("burst", int'(burst), m_burst);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    @(negedge clk);
    do_reset();

    // Single match on the 5th en cycle.
    repeat (4) step(1, 0, 1, 0);
    step(1, 1, 1, 0);
    chk("single_valid", int'(rpt_valid), 1);
    chk("single_idx", int'(rpt_idx), 0);
    chk("single_gap", int'(rpt_gap), 5);
    chk("single_count", int'(match_count), 1);
    step(1, 0, 1, 0);

    // Burst: match every 4 en cycles, then a long quiet stretch.
    step(0, 0, 1, 1);
    repeat (3) begin
      repeat (3) step(1, 0, 1, 0);
      step(1, 1, 1, 0);
    end
    chk("burst_rise", int'(burst), 1);
    repeat (17) step(1, 0, 1, 0);
    chk("burst_fall", int'(burst), 0);
    step(1, 1, 0, 0);
    chk("burst_gap_after", int'(rpt_gap), 18);
    chk("burst_after", int'(burst), 0);
    repeat (2) step(0, 0, 1, 0);

    // Overflow and ordering.
    step(0, 0, 0, 1);
    repeat (5) step(1, 1, 0, 0);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_count", int'(match_count), 5);
    repeat (5) step(0, 0, 1, 0);
    chk("ovf_drained", int'(rpt_valid), 0);

    // Full FIFO with simultaneous pop and push.
    step(0, 0, 0, 1);
    repeat (4) step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    chk("fullpp_ovf", int'(overflow), 0);
    step(1, 1, 0, 0);
    chk("fullpp_still_full", int'(overflow), 1);
    repeat (5) step(0, 0, 1, 0);

    // en gating and gap saturation.
    step(0, 0, 0, 1);
    for (int i = 0; i < 600; i++) step(i[0] == 1'b0, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("sat_gap", int'(rpt_gap), 255);

    // Clear together with a match.
    step(1, 1, 0, 1);
    chk("clr_valid", int'(rpt_valid), 0);
    chk("clr_count", int'(match_count), 0);

    // Asynchronous reset mid-drain with two reports held.
    repeat (2) step(1, 1, 0, 0);
    #1;
    do_reset();

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 199) == 0));
    end
    repeat (6) step(0, 0, 1, 0);
    chk("end_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
